// File: rtl/lt24_rect_fill_if.sv
// Command and pixel-stream bundle between a rectangle-fill producer and LT24Display.
// slave is the fill block itself; master is whoever issues commands and accepts pixels.
interface lt24_rect_fill_if #(
    parameter int X_BITS = 8,
    parameter int Y_BITS = 9
);
    logic [X_BITS-1:0] cmdX;
    logic [Y_BITS-1:0] cmdY;
    logic [X_BITS-1:0] cmdW;
    logic [Y_BITS-1:0] cmdH;
    logic [15:0]       cmdColour;
    logic              cmdValid;
    logic              cmdReady;
    logic              busy;
    logic              done;
    logic [X_BITS-1:0] xAddr;
    logic [Y_BITS-1:0] yAddr;
    logic [15:0]       pixelData;
    logic              pixelWrite;
    logic              pixelReady;

    modport master (
        output cmdX, cmdY, cmdW, cmdH, cmdColour, cmdValid, pixelReady,
        input  cmdReady, busy, done, xAddr, yAddr, pixelData, pixelWrite
    );

    modport slave (
        input  cmdX, cmdY, cmdW, cmdH, cmdColour, cmdValid, pixelReady,
        output cmdReady, busy, done, xAddr, yAddr, pixelData, pixelWrite
    );
endinterface

// File: rtl/lt24_rect_fill.sv
// Solid-colour rectangle filler: clips one command to the panel and streams its
// pixels in raster order (x fastest) to LT24Display, paced by pixelReady.
module lt24_rect_fill #(
    parameter int LCD_WIDTH  = 240,
    parameter int LCD_HEIGHT = 320,
    parameter int X_BITS     = 8,
    parameter int Y_BITS     = 9
) (
    input  logic           clock,
    input  logic           resetApp,
    lt24_rect_fill_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for a command, cmdReady high
    // SETUP | command latched, clip bounds settling
    // DRAW  | streaming pixels, one per accepted transfer
    // DONE  | single-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(LCD_WIDTH - 1);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(LCD_HEIGHT - 1);
    localparam logic [X_BITS:0]   X_ONE  = (X_BITS + 1)'(1);
    localparam logic [Y_BITS:0]   Y_ONE  = (Y_BITS + 1)'(1);

    state_t            state, state_next;
    logic [X_BITS-1:0] cmd_x, cmd_x_next, cmd_w, cmd_w_next;
    logic [Y_BITS-1:0] cmd_y, cmd_y_next, cmd_h, cmd_h_next;
    logic [15:0]       colour, colour_next;
    logic [X_BITS-1:0] x_addr, x_addr_next, x_end;
    logic [Y_BITS-1:0] y_addr, y_addr_next, y_end;
    logic [15:0]       pix_data, pix_data_next;
    logic              pix_write, pix_write_next;
    logic              busy_q, busy_next, done_q, done_next;
    logic [X_BITS:0]   x_sum;
    logic [Y_BITS:0]   y_sum;
    logic              empty;

    // One extra bit keeps x+w-1 from wrapping before it is clamped to the panel edge.
    always_comb begin
        x_sum = {1'b0, cmd_x} + {1'b0, cmd_w} - X_ONE;
        y_sum = {1'b0, cmd_y} + {1'b0, cmd_h} - Y_ONE;
        x_end = (x_sum > {1'b0, X_LAST}) ? X_LAST : x_sum[X_BITS-1:0];
        y_end = (y_sum > {1'b0, Y_LAST}) ? Y_LAST : y_sum[Y_BITS-1:0];
        empty = (cmd_w == '0) || (cmd_h == '0) || (cmd_x > X_LAST) || (cmd_y > Y_LAST);
    end

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            state     <= S_IDLE;
            cmd_x     <= '0;
            cmd_y     <= '0;
            cmd_w     <= '0;
            cmd_h     <= '0;
            colour    <= '0;
            x_addr    <= '0;
            y_addr    <= '0;
            pix_data  <= '0;
            pix_write <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_next;
            cmd_x     <= cmd_x_next;
            cmd_y     <= cmd_y_next;
            cmd_w     <= cmd_w_next;
            cmd_h     <= cmd_h_next;
            colour    <= colour_next;
            x_addr    <= x_addr_next;
            y_addr    <= y_addr_next;
            pix_data  <= pix_data_next;
            pix_write <= pix_write_next;
            busy_q    <= busy_next;
            done_q    <= done_next;
        end
    end

    always_comb begin
        state_next     = state;
        cmd_x_next     = cmd_x;
        cmd_y_next     = cmd_y;
        cmd_w_next     = cmd_w;
        cmd_h_next     = cmd_h;
        colour_next    = colour;
        x_addr_next    = x_addr;
        y_addr_next    = y_addr;
        pix_data_next  = pix_data;
        pix_write_next = pix_write;
        busy_next      = busy_q;
        done_next      = done_q;
        unique case (state)
            S_IDLE: begin
                if (bus.cmdValid) begin
                    cmd_x_next  = bus.cmdX;
                    cmd_y_next  = bus.cmdY;
                    cmd_w_next  = bus.cmdW;
                    cmd_h_next  = bus.cmdH;
                    colour_next = bus.cmdColour;
                    busy_next   = 1'b1;
                    state_next  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (empty) begin
                    done_next  = 1'b1;
                    state_next = S_DONE;
                end else begin
                    x_addr_next    = cmd_x;
                    y_addr_next    = cmd_y;
                    pix_data_next  = colour;
                    pix_write_next = 1'b1;
                    state_next     = S_DRAW;
                end
            end
            S_DRAW: begin
                if (pix_write && bus.pixelReady) begin
                    if (x_addr < x_end) begin
                        x_addr_next = x_addr + X_BITS'(1);
                    end else begin
                        x_addr_next = cmd_x;
                        if (y_addr < y_end) begin
                            y_addr_next = y_addr + Y_BITS'(1);
                        end else begin
                            pix_write_next = 1'b0;
                            done_next      = 1'b1;
                            state_next     = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                done_next  = 1'b0;
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.cmdReady   = (state == S_IDLE);
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.xAddr      = x_addr;
    assign bus.yAddr      = y_addr;
    assign bus.pixelData  = pix_data;
    assign bus.pixelWrite = pix_write;
endmodule
